// File: rtl/riscv_pkg.sv
// Core-wide constants shared by the integer pipeline, plus the register
// address validity rule used by the register file and its busy scoreboard.
package riscv_pkg;

    localparam int         XLEN     = 32;
    localparam int         NREG     = 32;
    localparam logic [4:0] REG_ZERO = 5'd0;

    // An address names a real, writable register: inside the array and not the hardwired zero.
    function automatic logic reg_valid(input logic [31:0] addr, input int nregs, input logic zero_reg);
        return (addr < 32'(nregs)) && !(zero_reg && (addr == 32'(REG_ZERO)));
    endfunction

endpackage

// File: rtl/regfile_mp_busy_sb.sv
// Per-register busy scoreboard: issue marks a destination pending, writeback
// clears it, flush clears everything.
module regfile_busy_sb
    import riscv_pkg::*;
#(
    parameter  int NUM_REGS = NREG,
    parameter  int ZERO_REG = 1,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr0_en,
    input  logic [AW-1:0]       wr0_addr,
    input  logic                wr1_en,
    input  logic [AW-1:0]       wr1_addr,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    input  logic                flush,
    output logic [NUM_REGS-1:0] busy,
    output logic                any_busy
);

    logic [NUM_REGS-1:0] busy_nxt;
    logic                wr0_ok;
    logic                wr1_ok;
    logic                iss_ok;

    assign wr0_ok = wr0_en && reg_valid(32'(wr0_addr), NUM_REGS, ZERO_REG != 0);
    assign wr1_ok = wr1_en && reg_valid(32'(wr1_addr), NUM_REGS, ZERO_REG != 0);
    assign iss_ok = iss_en && reg_valid(32'(iss_addr), NUM_REGS, ZERO_REG != 0);

    // Issue outranks writeback: the newly issued producer owns the register.
    always_comb begin
        busy_nxt = busy;
        if (flush) begin
            busy_nxt = '0;
        end else begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                if (iss_ok && (32'(iss_addr) == r)) begin
                    busy_nxt[r] = 1'b1;
                end else if ((wr0_ok && (32'(wr0_addr) == r)) ||
                             (wr1_ok && (32'(wr1_addr) == r))) begin
                    busy_nxt[r] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            any_busy <= 1'b0;
        end else begin
            busy     <= busy_nxt;
            any_busy <= |busy_nxt;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file: two write ports (wr1 wins on collision),
// NUM_RD combinational read ports with optional write bypass, busy scoreboard.
module regfile_mp
    import riscv_pkg::*;
#(
    parameter  int DATA_W   = XLEN,
    parameter  int NUM_REGS = NREG,
    parameter  int NUM_RD   = 2,
    parameter  int ZERO_REG = 1,
    parameter  int BYPASS   = 1,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr0_en,
    input  logic [AW-1:0]            wr0_addr,
    input  logic [DATA_W-1:0]        wr0_data,
    input  logic                     wr1_en,
    input  logic [AW-1:0]            wr1_addr,
    input  logic [DATA_W-1:0]        wr1_data,
    input  logic                     iss_en,
    input  logic [AW-1:0]            iss_addr,
    input  logic                     flush,
    output logic                     any_busy
);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic                wr0_ok;
    logic                wr1_ok;

    assign wr0_ok = wr0_en && reg_valid(32'(wr0_addr), NUM_REGS, ZERO_REG != 0);
    assign wr1_ok = wr1_en && reg_valid(32'(wr1_addr), NUM_REGS, ZERO_REG != 0);

    // wr1 is applied last so it wins a same-address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wr0_ok) regs[wr0_addr] <= wr0_data;
            if (wr1_ok) regs[wr1_addr] <= wr1_data;
        end
    end

    regfile_busy_sb #(
        .NUM_REGS (NUM_REGS),
        .ZERO_REG (ZERO_REG)
    ) u_busy (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr0_en   (wr0_en),
        .wr0_addr (wr0_addr),
        .wr1_en   (wr1_en),
        .wr1_addr (wr1_addr),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .flush    (flush),
        .busy     (busy),
        .any_busy (any_busy)
    );

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0]     a;
        logic              a_ok;
        logic              hit0;
        logic              hit1;
        logic              iss_hit;
        logic [DATA_W-1:0] d;
        logic              b;

        assign a       = rd_addr[k*AW +: AW];
        assign a_ok    = reg_valid(32'(a), NUM_REGS, ZERO_REG != 0);
        assign hit0    = wr0_ok && (wr0_addr == a);
        assign hit1    = wr1_ok && (wr1_addr == a);
        assign iss_hit = iss_en && (iss_addr == a);

        // Outputs are held at zero while reset is asserted, even if a write is pending.
        always_comb begin
            d = '0;
            b = 1'b0;
            if (rst_n && a_ok) begin
                d = regs[a];
                b = busy[a];
                if (BYPASS != 0) begin
                    if (hit1)      d = wr1_data;
                    else if (hit0) d = wr0_data;
                    if ((hit0 || hit1) && !iss_hit) b = 1'b0;
                end
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = d;
        assign rd_busy[k]                  = b;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port integer register file, successor to the single-write/dual-read core register file. Adds configurable width, depth and read-port count, a second write port, and optional write-to-read bypass. Also adds a per-register busy scoreboard: issue marks a register pending; writeback clears it. Sits between decode (reads, issue), the execute/load writeback paths (two write ports) and the hazard unit (busy outputs).

Parameters:
DATA_W, 32, register data width in bits
NUM_REGS, 32, number of architectural registers (2..64, need not be a power of two)
NUM_RD, 2, number of combinational read ports (1..4)
ZERO_REG, 1, 1 = register 0 hardwired to zero and never busy
BYPASS, 1, 1 = same-cycle write data and busy-clear forwarded to read ports
AW (localparam), $clog2(NUM_REGS), address width

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
rd_addr  in  NUM_RD*AW  read addresses, port k at bits [k*AW +: AW]
rd_data  out  NUM_RD*DATA_W  read data, port k at bits [k*DATA_W +: DATA_W]
rd_busy  out  NUM_RD  1 = register on port k has a pending producer
wr0_en  in  1  write port 0 enable (ALU writeback)
wr0_addr  in  AW  write port 0 address
wr0_data  in  DATA_W  write port 0 data
wr1_en  in  1  write port 1 enable (load writeback)
wr1_addr  in  AW  write port 1 address
wr1_data  in  DATA_W  write port 1 data
iss_en  in  1  issue: mark iss_addr busy
iss_addr  in  AW  destination register of issued instruction
flush  in  1  clear all busy bits (pipeline flush); register contents untouched
any_busy  out  1  OR of all busy bits

Behaviour:
- Reset (rst_n low, asynchronous): all registers 0, all busy bits 0; rd_data = 0, rd_busy = 0, any_busy = 0 while reset is held. Reset mid-operation discards any in-flight write in that cycle.
- Writes: synchronous, one cycle. Register[a] takes the new value at the clock edge after the write-enable cycle.
- Both ports write the same address in one cycle: wr1 wins.
- Different addresses: both writes commit.
- Address 0 with ZERO_REG=1, or address >= NUM_REGS: write ignored.
- Reads: combinational, zero latency.
- Read returns 0 for address 0 (ZERO_REG=1) or for address >= NUM_REGS.
- BYPASS=1: a read matching an enabled, valid write address this cycle returns that write data, with wr1 taking priority over wr0. BYPASS=0: a read returns the stored value, so new data is visible the cycle after the write.
- Busy next-state per register r, in priority order:
  - flush sets all to 0, overriding issue and writeback in the same cycle.
  - Otherwise iss_en && iss_addr==r sets 1. Issue beats a same-cycle writeback to r, because the new producer owns the register.
  - Otherwise a write to r on either port clears it.
  - Otherwise it holds.
- Busy is never set for register 0 (ZERO_REG=1) or for out-of-range addresses.
- rd_busy[k] is the registered busy bit of rd_addr[k].
  - With BYPASS=1 it is forced to 0 when a same-cycle write targets that address and no same-cycle issue targets it.
  - Same-cycle issue does not raise rd_busy; it takes effect the next cycle.
- any_busy is the registered OR of busy bits, with no bypass.
- Re-issue to an already-busy register keeps it busy; a single writeback clears it. There is no per-register producer count.

Decomposition:
- Shared package (riscv_pkg): XLEN=32, NREG=32, REG_ZERO=5'd0 constants; regfile_mp defaults take these.
- One natural sub-module, regfile_busy_sb: busy bit vector, issue/writeback/flush priority, any_busy.
- Data array, write arbitration and read/bypass muxing stay in regfile_mp, using a generate loop over NUM_RD.

Test Plan:
1. Reset then read: hold rst_n=0 with wr0_en=1 to x5. Release, read x5 -> 0. rd_busy=0, any_busy=0.
2. Write x3=0xDEADBEEF on wr0. Same cycle, BYPASS=1: rd_data=0xDEADBEEF. Next cycle it is stored. With BYPASS=0, the same-cycle read returns 0.
3. Dual write to x7, wr0=0x11111111 and wr1=0x22222222 -> x7=0x22222222. Then write x0=0xFFFFFFFF -> x0 reads 0.
4. Scoreboard:
   - Issue x9 -> rd_busy=1 next cycle.
   - Write x9 on wr1 -> rd_busy=0 same cycle (BYPASS=1), busy bit clear next cycle.
   - Issue and write x9 in the same cycle -> busy stays 1.
5. Set busy on x4 and x12, then assert flush together with iss_en on x6 -> all busy 0, any_busy=0, x4/x12 data unchanged.
6. NUM_REGS=24, NUM_RD=3, DATA_W=64: write address 25 ignored; read of 25 -> 0; all three ports read x1, x2, x23 correctly after writes.
